rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Boot-stage block upstream of the Hack computer.
- Accepts a byte stream from a serial receiver using a valid/ready handshake and writes 16-bit instruction words into the instruction ROM through its write port.
- Holds the computer in reset while loading and releases it once a complete image is accepted.
- Replaces simulation-only $readmemb image loading with an in-system load path.

Parameters:
- ADDR_W, 15, ROM address width; ROM depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid & in_ready at a rising edge.
- reload  input  1  single-cycle request to start a new load; honoured only in RUN or ERROR.
- rom_we  output  1  ROM write strobe, one cycle per word.
- rom_addr  output  ADDR_W  ROM write address.
- rom_data  output  16  ROM write data.
- cpu_reset  output  1  active-high reset to the computer.
- done  output  1  image loaded and computer released.
- error  output  1  load failed.

Behaviour:
- Stream format, all fields big-endian:
  - LEN_HI, LEN_LO: word count N, 16 bits.
  - N words, each HI byte then LO byte.
  - Checksum byte, only when the optional feature is compiled in.
- Reset (reset=0 at an edge) puts the block in LEN_HI with these output values:
  - in_ready=1, rom_we=0, rom_addr=0, rom_data=0, cpu_reset=1, done=0, error=0.
  - Word counter=0, checksum accumulator=0.
- Reset mid-load aborts the load. Words already written are not rolled back.
- States and transitions (each happens on an accepted byte unless noted):
  - LEN_HI: latch high byte of N -> LEN_LO.
  - LEN_LO: latch low byte of N.
    - N > 2**ADDR_W -> ERROR.
    - N == 0 -> CHECK if the feature is enabled, else RUN.
    - Otherwise -> DATA_HI.
  - DATA_HI: latch high byte -> DATA_LO.
  - DATA_LO: form the word.
    - Next cycle: rom_we=1, rom_addr=word index, rom_data={hi,lo}.
    - Word index increments after the write.
    - Index == N-1 -> CHECK if the feature is enabled, else RUN.
    - Otherwise -> DATA_HI.
  - CHECK: compare the received byte with the accumulator; match -> RUN, else ERROR.
  - RUN: in_ready=0, cpu_reset=0, done=1. Entry happens on the edge after the final byte; cpu_reset falls the same cycle done rises.
  - ERROR: in_ready=0, cpu_reset=1, error=1. Sticky until reset or reload.
- reload in RUN or ERROR:
  - Next state LEN_HI; counters and accumulator cleared.
  - cpu_reset=1, done=0, error=0 from the next cycle.
  - reload is ignored in all other states.
- rom_we:
  - Never high for two consecutive cycles.
  - The final write's pulse coincides with the first RUN/CHECK cycle.
  - rom_addr/rom_data hold their last values when rom_we=0.
- in_ready is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. in_valid without in_ready is ignored, with no buffering.
- N is compared as an unsigned 17-bit value against 2**ADDR_W. rom_addr takes the low ADDR_W bits of the index, so N == 2**ADDR_W fills the ROM exactly with no wrap.

Optional Feature:
- Macro: ROM_LOADER_CSUM_EN.
- Defined:
  - The accumulator sums every accepted byte (length and data bytes) modulo 256.
  - A trailing checksum byte is expected and checked in CHECK.
- Undefined:
  - No accumulator and no CHECK state.
  - The final DATA_LO or a zero N goes directly to RUN.
  - Stream has no trailing byte.

Test Plan:
- Basic load, feature on. Stream 00 02 00 02 EC 10 00 (checksum 0x00) ->
  - writes: addr0=0x0002, addr1=0xEC10;
  - then done=1, cpu_reset=0, error=0, in_ready=0.
- Bad checksum. Same stream with final byte 0x01 ->
  - both writes occur;
  - then error=1, cpu_reset=1, done=0.
  - Then pulse reload and send the good stream -> done=1.
- Backpressure / gaps. Same good stream with in_valid deasserted 3 cycles between each byte ->
  - identical writes and result;
  - exactly two rom_we pulses.
- Oversize. With ADDR_W=4, send N = 00 11 (17) ->
  - ERROR immediately after LEN_LO;
  - no rom_we.
  - With N = 00 10, 16 words 0x0000..0x000F plus checksum -> addresses 0..15 written, done=1.
- Zero length. 00 00 00 with the feature on, or 00 00 with it off ->
  - RUN with no writes.
- Reset mid-load. reset=0 after the first DATA_LO ->
  - one write completed;
  - outputs return to reset values;
  - a fresh full stream then loads correctly.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader
// Boot-stage loader for the Hack computer. It takes a byte stream over a
// valid/ready handshake and writes 16-bit words into the instruction ROM
// write port. While an image loads, the computer is held in reset. The
// computer is released once the whole image has been accepted.
//
// Stream (big-endian): LEN_HI, LEN_LO, then N words as HI/LO byte pairs.
// When ROM_LOADER_CSUM_EN is defined, one more byte follows the words. That
// byte must equal the modulo-256 sum of every earlier byte in the stream.
//
// Optional feature macro: ROM_LOADER_CSUM_EN (undefined by default).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   in_data    stream byte
//   in_valid   in_data valid
//   in_ready   loader accepts a byte this cycle
//   reload     single-cycle request to restart loading (RUN/ERROR only)
//   rom_we     ROM write strobe, one cycle per word
//   rom_addr   ROM write address (ADDR_W bits)
//   rom_data   ROM write data
//   cpu_reset  active-high reset to the computer
//   done       image loaded, computer released
//   error      load failed (sticky until reset or reload)

module rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_LEN_HI  = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_DATA_HI = 3'd2,
        ST_DATA_LO = 3'd3,
`ifdef ROM_LOADER_CSUM_EN
        ST_CHECK   = 3'd4,
`endif
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    // Length is compared as 17 bits so that N == 2**ADDR_W is legal.
    localparam logic [16:0] ROM_DEPTH = 17'd1 << ADDR_W;

    state_t      state_r;
    logic [7:0]  len_hi_r;
    logic [15:0] len_r;
    logic [7:0]  data_hi_r;
    logic [16:0] word_idx_r;

    logic        accept_s;
    logic [16:0] len_in_s;
    logic        last_word_s;

    assign accept_s    = in_valid & in_ready;
    assign len_in_s    = {1'b0, len_hi_r, in_data};
    assign last_word_s = ((word_idx_r + 17'd1) == {1'b0, len_r});

`ifdef ROM_LOADER_CSUM_EN
    logic [7:0] csum_r;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    // Loader FSM with registered handshake, ROM-write and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_LEN_HI;
            in_ready   <= 1'b1;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= 16'h0000;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            len_hi_r   <= 8'h00;
            len_r      <= 16'h0000;
            data_hi_r  <= 8'h00;
            word_idx_r <= 17'd0;
`ifdef ROM_LOADER_CSUM_EN
            csum_r     <= 8'h00;
`endif
        end else begin
            // The write strobe is a pulse. The address and data registers keep their values.
            rom_we <= 1'b0;
`ifdef ROM_LOADER_CSUM_EN
            // The checksum byte also accumulates here. That is harmless, because leaving CHECK ends the load.
            if (accept_s) begin
                csum_r <= csum_add(csum_r, in_data);
            end
`endif
            case (state_r)
                ST_LEN_HI: begin
                    if (accept_s) begin
                        len_hi_r <= in_data;
                        state_r  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_r <= len_in_s[15:0];
                        if (len_in_s > ROM_DEPTH) begin
                            state_r  <= ST_ERROR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else if (len_in_s == 17'd0) begin
`ifdef ROM_LOADER_CSUM_EN
                            state_r   <= ST_CHECK;
`else
                            state_r   <= ST_RUN;
                            in_ready  <= 1'b0;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            state_r <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (accept_s) begin
                        data_hi_r <= in_data;
                        state_r   <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (accept_s) begin
                        rom_we     <= 1'b1;
                        rom_addr   <= word_idx_r[ADDR_W-1:0];
                        rom_data   <= {data_hi_r, in_data};
                        word_idx_r <= word_idx_r + 17'd1;
                        if (last_word_s) begin
`ifdef ROM_LOADER_CSUM_EN
                            state_r   <= ST_CHECK;
`else
                            state_r   <= ST_RUN;
                            in_ready  <= 1'b0;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            state_r <= ST_DATA_HI;
                        end
                    end
                end
`ifdef ROM_LOADER_CSUM_EN
                ST_CHECK: begin
                    if (accept_s) begin
                        in_ready <= 1'b0;
                        if (in_data == csum_r) begin
                            state_r   <= ST_RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_r <= ST_ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                ST_RUN, ST_ERROR: begin
                    if (reload) begin
                        state_r    <= ST_LEN_HI;
                        in_ready   <= 1'b1;
                        cpu_reset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        len_hi_r   <= 8'h00;
                        len_r      <= 16'h0000;
                        word_idx_r <= 17'd0;
`ifdef ROM_LOADER_CSUM_EN
                        csum_r     <= 8'h00;
`endif
                    end
                end
                default: begin
                    // An unreachable encoding fails safe and holds the computer in reset.
                    state_r   <= ST_ERROR;
                    in_ready  <= 1'b0;
                    cpu_reset <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
// Self-checking bench for rom_loader, using ADDR_W=4 so the boundary cases
// stay small. Expected ROM writes and final status come from a stream-level
// reference model that parses the byte queue directly.
// Optional feature macro honoured: ROM_LOADER_CSUM_EN.

module tb_rom_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
`ifdef ROM_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int  errors = 0;
    int  checks = 0;
    wr_t seen_q[$];
    wr_t exp_q[$];
    logic prev_we = 1'b0;

    rom_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .rom_we(rom_we), .rom_addr(rom_addr),
        .rom_data(rom_data), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every ROM write and flag back-to-back strobes.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            seen_q.push_back(wr_t'({rom_addr, rom_data}));
            checks++;
            assert (prev_we !== 1'b1) else begin
                errors++;
                $error("FAIL rom_we_back_to_back observed=1 expected=0");
            end
        end
        prev_we = rom_we;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_rom_we"}, 32'(rom_we), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_rom_data"}, 32'(rom_data), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    // Send the first count bytes of s. gap<0 inserts a random 0..2 idle cycles before each byte after the first.
    task automatic send(input bq_t s, input int count, input int gap);
        int g;
        int budget;
        for (int k = 0; k < count; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (k > 0) begin
                for (int j = 0; j < g; j++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = s[k];
            budget   = 0;
            while (in_ready !== 1'b1 && budget < 50) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 50) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Reference model: parse the stream, then predict the writes, the bytes consumed and the outcome.
    task automatic run_stream(input string tag, input bq_t s, input int gap);
        int         n;
        int         consumed;
        bit         ok;
        logic [7:0] sum;
        n = int'({s[0], s[1]});
        exp_q.delete();
        if (n > DEPTH) begin
            consumed = 2;
            ok       = 1'b0;
        end else begin
            sum = s[0] + s[1];
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(wr_t'({AW'(i), s[2 + 2 * i], s[3 + 2 * i]}));
                sum = sum + s[2 + 2 * i] + s[3 + 2 * i];
            end
            consumed = 2 + 2 * n + (CSUM ? 1 : 0);
            ok       = CSUM ? (s[2 + 2 * n] == sum) : 1'b1;
        end
        seen_q.delete();
        send(s, consumed, gap);
        // First cycle after the final accepted byte.
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(ok));
        check({tag, "_error"}, 32'(error), 32'(!ok));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_last_we"}, 32'(rom_we), 32'(!CSUM && ok && n > 0));
        // Offered bytes must now be ignored.
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_hold_done"}, 32'(done), 32'(ok));
        check({tag, "_wr_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++) begin
            check({tag, "_wr"}, 32'(seen_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic pulse_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    function automatic bq_t mk_stream(input int n, input bit corrupt);
        bq_t        s;
        logic [7:0] sum;
        logic [15:0] w;
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        sum = s[0] + s[1];
        for (int i = 0; i < n && i < DEPTH + 2; i++) begin
            w = 16'($urandom);
            s.push_back(w[15:8]);
            s.push_back(w[7:0]);
            sum = sum + w[15:8] + w[7:0];
        end
        s.push_back(corrupt ? (sum ^ 8'h5A) : sum);
        return s;
    endfunction

    initial begin
        bq_t good;
        bq_t bad;
        bq_t s;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_reset_outputs("reset");

        good = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00};
        bad  = '{8'h00, 8'h02, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h01};
        run_stream("basic", good, 0);
        pulse_reload("reload1");
        run_stream("badsum", bad, 0);
        pulse_reload("reload2");
        run_stream("after_reload", good, 0);
        pulse_reload("reload3");
        run_stream("gaps", good, 3);
        pulse_reload("reload4");

        s = '{8'h00, 8'h11, 8'h00, 8'h00};
        run_stream("oversize", s, 0);
        pulse_reload("reload5");

        s = '{8'h00, 8'h10};
        for (int i = 0; i < DEPTH; i++) begin
            s.push_back(8'h00);
            s.push_back(8'(i));
        end
        s.push_back(8'h88);  // 0x10 + (0+1+...+15) = 136
        run_stream("full", s, 0);
        pulse_reload("reload6");

        s = '{8'h00, 8'h00, 8'h00};
        run_stream("zero_len", s, 0);
        pulse_reload("reload7");

        // Reset partway through the load; the first word is already written.
        seen_q.delete();
        send(good, 4, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        check("midreset_wr_count", 32'(seen_q.size()), 32'd1);
        if (seen_q.size() > 0) begin
            check("midreset_wr", 32'(seen_q[0]), 32'(wr_t'({AW'(0), 16'h0002})));
        end
        run_stream("fresh", good, 0);

        for (int r = 0; r < 10; r++) begin
            pulse_reload("rnd_reload");
            s = mk_stream(int'($urandom_range(0, DEPTH + 1)), ($urandom_range(0, 3) == 0));
            run_stream("rnd", s, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
